uart_rx_frontend: RTL and testbench

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_rx_frontend_if.sv | 33 +++
 rtl/uart_rx_frontend.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frontend_if.sv
// ============================================================================
// Module      : uart_rx_frontend_if
// Description : Serial line, acknowledge and status bundle for uart_rx_frontend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_frontend_if #(
  parameter int DW = 8
);
  typedef logic [DW-1:0] data_t;

  logic  rx;
  logic  clear_interrupt;
  data_t data;
  logic  rx_interrupt;
  logic  overrun;
  logic  framing_error;
  logic  busy;

  // master: line driver / byte consumer; slave: the receiver itself
  modport master (
    output rx, clear_interrupt,
    input  data, rx_interrupt, overrun, framing_error, busy
  );

  modport slave (
    input  rx, clear_interrupt,
    output data, rx_interrupt, overrun, framing_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frontend.sv
// ============================================================================
// Module      : uart_rx_frontend
// Description : 16x-oversampled UART receiver with interrupt/overrun flags.
//               Optional even parity bit when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend #(
  parameter int BAUD_DIV = 27,
  parameter int DW       = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_frontend_if.slave   bus
);

  localparam int               c_BCW      = $clog2(DW + 1);
  localparam logic [15:0]      c_TICK_MAX = 16'(BAUD_DIV - 1);
  localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [15:0]      r_tick_cnt;
  logic [3:0]       r_os_cnt;
  logic [c_BCW-1:0] r_bit_cnt;
  logic [DW-1:0]    r_shift;
  logic [DW-1:0]    r_data;
  logic             r_irq;
  logic             r_ovr;
  logic             r_ferr;
  logic             r_busy;
`ifdef UART_RX_PARITY_EN
  logic             r_par_ok;
`endif

  logic w_tick;
  logic w_fall;
  logic w_mid_start;
  logic w_bit_end;
  logic w_frame_ok;

  assign w_tick      = (r_state != S_IDLE) && (r_tick_cnt == c_TICK_MAX);
  assign w_fall      = r_rx_prev && !r_rx_sync;
  assign w_mid_start = w_tick && (r_os_cnt == 4'd7);
  assign w_bit_end   = w_tick && (r_os_cnt == 4'd15);
`ifdef UART_RX_PARITY_EN
  assign w_frame_ok  = r_rx_sync && r_par_ok;
`else
  assign w_frame_ok  = r_rx_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_irq      <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok   <= 1'b1;
`endif
    end else begin
      r_ferr     <= 1'b0;
      r_tick_cnt <= (r_state == S_IDLE || w_tick) ? 16'd0 : r_tick_cnt + 16'd1;
      if (w_tick) r_os_cnt <= r_os_cnt + 4'd1;

      // Acknowledge first; a byte completing this same cycle overrides below.
      if (bus.clear_interrupt) begin
        r_irq <= 1'b0;
        r_ovr <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_os_cnt <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_mid_start) begin
            if (r_rx_sync) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift   <= {r_rx_sync, r_shift[DW-1:1]};
            r_bit_cnt <= r_bit_cnt + c_BCW'(1);
            if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_par_ok <= ~(^r_shift ^ r_rx_sync);
            r_state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_frame_ok) begin
              r_data <= r_shift;
              r_irq  <= 1'b1;
              r_ovr  <= !bus.clear_interrupt && (r_irq || r_ovr);
            end else begin
              r_ferr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data          = r_data;
  assign bus.rx_interrupt  = r_irq;
  assign bus.overrun       = r_ovr;
  assign bus.framing_error = r_ferr;
  assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
// Module      : tb_uart_rx_frontend
// Description : Scoreboard bench for uart_rx_frontend at BAUD_DIV=2 (32 clk/bit).
//               Adds parity frames when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frontend;

  localparam int c_BIT_CLKS = 32;

  typedef struct {
    logic [7:0] data;
    logic       irq;
    logic       ovr;
    logic       ferr;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_checks;
  int   n_errs;
  logic [7:0] m_data;
  logic       m_irq;
  logic       m_ovr;

  uart_rx_frontend_if #(.DW(8)) bus ();

  uart_rx_frontend #(
    .BAUD_DIV (2),
    .DW       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    repeat (c_BIT_CLKS) begin
      @(negedge clk);
      bus.rx = v;
    end
  endtask

  // Expected post-frame state is predicted here, in program order.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input logic coinc, input logic par_flip);
    logic good;
    exp_t e;
    good = stop_b;
`ifdef UART_RX_PARITY_EN
    good = stop_b && !par_flip;
`endif
    if (good) begin
      if (coinc)      m_ovr = 1'b0;
      else if (m_irq) m_ovr = 1'b1;
      m_irq  = 1'b1;
      m_data = b;
    end
    e = '{data: m_data, irq: m_irq, ovr: m_ovr, ferr: !good};
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    for (int c = 0; c < c_BIT_CLKS; c++) begin
      @(negedge clk);
      bus.rx = stop_b;
      bus.clear_interrupt = coinc && (c == 18);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frame_timeout", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.clear_interrupt = 1'b1;
    m_irq = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    bus.clear_interrupt = 1'b0;
    @(negedge clk);
    check("clr_irq", 32'(bus.rx_interrupt), 32'(m_irq));
    check("clr_ovr", 32'(bus.overrun), 32'(m_ovr));
  endtask

  // Each busy fall outside reset marks a finished frame or a rejected start.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && prev_busy && !bus.busy) begin
        check("frame_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("data", 32'(bus.data), 32'(e.data));
          check("irq", 32'(bus.rx_interrupt), 32'(e.irq));
          check("ovr", 32'(bus.overrun), 32'(e.ovr));
          check("ferr", 32'(bus.framing_error), 32'(e.ferr));
          if (e.ferr) begin
            @(negedge clk);
            check("ferr_width", 32'(bus.framing_error), 32'd0);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    exp_t e;
    n_checks = 0;
    n_errs   = 0;
    rst = 1'b0;
    bus.rx = 1'b1;
    bus.clear_interrupt = 1'b0;
    m_data = 8'h00;
    m_irq  = 1'b0;
    m_ovr  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.data), 32'h0);
    check("rst_irq", 32'(bus.rx_interrupt), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    check("rst_ferr", 32'(bus.framing_error), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'hFE, 1'b1, 1'b0, 1'b0);
    wait_done();
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    clear_pulse();

    // false start: 6 clk low is far short of the mid-start sample
    e = '{data: m_data, irq: m_irq, ovr: m_ovr, ferr: 1'b0};
    q.push_back(e);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (6) @(negedge clk);
    bus.rx = 1'b1;
    wait_done();
    check("false_start_busy", 32'(bus.busy), 32'd0);

    send_frame(8'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.rx = 1'b1;
    wait_done();
    repeat (40) @(negedge clk);

    send_frame(8'hFE, 1'b1, 1'b0, 1'b0);
    send_frame(8'hEF, 1'b1, 1'b0, 1'b0);
    wait_done();
    clear_pulse();

    send_frame(8'hFE, 1'b1, 1'b0, 1'b0);
    send_frame(8'hEF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_done();
    clear_pulse();

    // reset in the middle of 0x55, after four data bits
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_data", 32'(bus.data), 32'h0);
    m_data = 8'h00;
    m_irq  = 1'b0;
    m_ovr  = 1'b0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    wait_done();
    repeat (400) @(negedge clk);
    check("post_rst_data", 32'(bus.data), 32'h01);
    clear_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_done();
    clear_pulse();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_done();
    check("par_bad_irq", 32'(bus.rx_interrupt), 32'd0);
`endif

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
